// File: rtl/data_ram_resp_if.sv
// data_ram_resp_if: load/store request/response bus between CPU memory stage and RAM responder
// Signal suffixes are from the responder's point of view:
//   req_i/we_i/addr_i/sel_i/wdata_i  request driven by the master
//   ready_o/rdata_o/err_o            one-cycle response driven by the slave
interface data_ram_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        err_o;
  modport master (output req_i, we_i, addr_i, sel_i, wdata_i, input ready_o, rdata_o, err_o);
  modport slave (input req_i, we_i, addr_i, sel_i, wdata_i, output ready_o, rdata_o, err_o);
endinterface

// File: rtl/data_ram_resp.sv
// data_ram_resp: byte-lane masked 32-bit RAM responder with programmable wait states
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-low reset (memory array is never cleared)
//   bus  data_ram_if slave: req/we/addr/sel/wdata in, ready/rdata/err out
module data_ram_resp #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input logic       clk,
  input logic       rst,
  data_ram_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we;
  logic        bad;
  logic [31:0] mask;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0] mem [2**ADDR_WIDTH];
  // only the word address is latched; byte offset is the requester's concern
  assign idx  = addr_q[ADDR_WIDTH-1:0];
  assign bad  = ((addr_q >> ADDR_WIDTH) != 30'd0) || (sel_q == 4'd0);
  assign mask = {{8{sel_q[3]}}, {8{sel_q[2]}}, {8{sel_q[1]}}, {8{sel_q[0]}}};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: if (bus.req_i) begin
        we_d    = bus.we_i;
        addr_d  = bus.addr_i[31:2];
        sel_d   = bus.sel_i;
        wdata_d = bus.wdata_i;
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = BUSY;
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      else begin
        ready_d = 1'b1;
        err_d   = bad;
        rdata_d = (bad || we_q) ? 32'd0 : (mem[idx] & mask);
        mem_we  = !bad && we_q;
        state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  // reset gates the write so an access caught by reset in BUSY never lands
  always_ff @(posedge clk) begin
    if (mem_we && rst)
      for (int k = 0; k < 4; k++)
        if (sel_q[k]) mem[idx][8*k+:8] <= wdata_q[8*k+:8];
  end
  assign bus.ready_o = ready_q;
  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;
endmodule

// File: tb/tb_data_ram_resp.sv
// tb_data_ram_resp: randomized self-checking bench for data_ram_resp at WAIT_CYCLES 0, 1 and 5
module tb_data_ram_resp;
  localparam int WS[3] = '{0, 1, 5};
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic [2:0]  rdy, er;
  logic [31:0] rd [3];
  int tests = 0;
  int fails = 0;
  logic [31:0] mdl [int];
  always #5 clk = ~clk;
  data_ram_if ifs [3] ();
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].req_i   = req[g];
    assign ifs[g].we_i    = we;
    assign ifs[g].addr_i  = addr;
    assign ifs[g].sel_i   = sel;
    assign ifs[g].wdata_i = wdata;
    assign rdy[g] = ifs[g].ready_o;
    assign rd[g]  = ifs[g].rdata_o;
    assign er[g]  = ifs[g].err_o;
    data_ram_resp #(.ADDR_WIDTH(12), .WAIT_CYCLES(WS[g])) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(ifs[g].slave)
    );
  end
  // reference: 16 KB per instance, byte addresses at or above 0x4000 or an empty strobe are errors
  task automatic model(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, output logic [31:0] exp_r, output logic exp_e);
    int key;
    logic [31:0] word;
    exp_r = 32'd0;
    exp_e = (a >= 32'h4000) || (s == 4'd0);
    if (!exp_e) begin
      key  = d * 4096 + int'(a / 4);
      word = mdl.exists(key) ? mdl[key] : 32'd0;
      for (int k = 0; k < 4; k++)
        if (s[k]) begin
          if (w) word[8*k+:8] = wd[8*k+:8];
          else exp_r[8*k+:8] = word[8*k+:8];
        end
      if (w) mdl[key] = word;
    end
  endtask
  // one request; lat is the cycle of ready counted from the req cycle, one is set if ready lasted one cycle
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] wd, output logic [31:0] rdat, output logic e,
                      output int lat, output logic one);
    @(posedge clk); #1;
    we = w; addr = a; sel = s; wdata = wd; req[d] = 1'b1;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy[d]) begin lat = c; break; end
    end
    rdat = rd[d];
    e = er[d];
    @(posedge clk); #1;
    req[d] = 1'b0;
    @(negedge clk);
    one = !rdy[d];
  endtask
  task automatic test_reset;
    int lat;
    logic [31:0] xr;
    logic xe;
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h40; sel = 4'hF; wdata = 32'hA5A50F0F; req[1] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({rdy[1], er[1], rd[1]} !== 34'd0) begin
      fails++;
      $display("FAIL reset_outputs: ready=%b err=%b rdata=%h, need 0/0/0", rdy[1], er[1], rd[1]);
    end
    rst = 1'b1;
    lat = -1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (rdy[1]) begin lat = c; break; end
    end
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL reset_release_latency: ready after %0d cycles, need 3", lat);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    model(1, 1'b1, 32'h40, 4'hF, 32'hA5A50F0F, xr, xe);
  endtask
  task automatic init_mem;
    logic [31:0] xr, r;
    logic xe, e, one;
    int lat;
    for (int d = 0; d < 3; d++)
      for (int wd = 0; wd < 16; wd++) begin
        model(d, 1'b1, wd * 4, 4'hF, $urandom, xr, xe);
        xact(d, 1'b1, wd * 4, 4'hF, mdl[d * 4096 + wd], r, e, lat, one);
      end
  endtask
  task automatic test_word;
    logic [31:0] r, xr;
    logic e, xe, one;
    int lat;
    model(1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, xr, xe);
    xact(1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, r, e, lat, one);
    tests++;
    if (lat != 3 || r !== 32'd0 || e !== 1'b0 || !one) begin
      fails++;
      $display("FAIL word_write: lat=%0d rdata=%h err=%b single=%b, need 3/0/0/1", lat, r, e, one);
    end
    xact(1, 1'b0, 32'h100, 4'hF, 32'h0, r, e, lat, one);
    tests++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      fails++;
      $display("FAIL word_read: rdata=%h err=%b, need deadbeef/0", r, e);
    end
  endtask
  task automatic test_lanes;
    logic [31:0] r, xr;
    logic e, xe, one;
    int lat;
    model(1, 1'b1, 32'h101, 4'b0010, 32'h0000AA00, xr, xe);
    xact(1, 1'b1, 32'h101, 4'b0010, 32'h0000AA00, r, e, lat, one);
    xact(1, 1'b0, 32'h100, 4'hF, 32'h0, r, e, lat, one);
    tests++;
    if (r !== 32'hDEADAAEF) begin
      fails++;
      $display("FAIL byte_lane_write: rdata=%h, need deadaaef", r);
    end
    xact(1, 1'b0, 32'h102, 4'b1100, 32'h0, r, e, lat, one);
    tests++;
    if (r !== 32'hDEAD0000) begin
      fails++;
      $display("FAIL halfword_read: rdata=%h, need dead0000", r);
    end
  endtask
  task automatic test_errors;
    logic [31:0] r, xr;
    logic e, xe, one;
    int lat;
    xact(1, 1'b1, 32'h4000, 4'hF, 32'hFFFF_FFFF, r, e, lat, one);
    tests++;
    if (e !== 1'b1 || r !== 32'd0 || lat != 3) begin
      fails++;
      $display("FAIL err_range_write: err=%b rdata=%h lat=%0d, need 1/0/3", e, r, lat);
    end
    model(1, 1'b0, 32'h0, 4'hF, 32'h0, xr, xe);
    xact(1, 1'b0, 32'h0, 4'hF, 32'h0, r, e, lat, one);
    tests++;
    if (r !== xr || e !== 1'b0) begin
      fails++;
      $display("FAIL err_no_alias_write: rdata=%h err=%b, need %h/0", r, e, xr);
    end
    xact(1, 1'b0, 32'h100, 4'h0, 32'h0, r, e, lat, one);
    tests++;
    if (e !== 1'b1 || r !== 32'd0) begin
      fails++;
      $display("FAIL err_empty_sel: err=%b rdata=%h, need 1/0", e, r);
    end
    xact(1, 1'b0, 32'h100, 4'hF, 32'h0, r, e, lat, one);
    tests++;
    if (e !== 1'b0) begin
      fails++;
      $display("FAIL err_cleared: err=%b, need 0", e);
    end
  endtask
  task automatic test_timing;
    logic [31:0] r;
    logic e, one;
    int lat;
    for (int d = 0; d < 3; d++) begin
      xact(d, 1'b0, 32'h8, 4'hF, 32'h0, r, e, lat, one);
      tests++;
      if (lat != WS[d] + 2 || !one) begin
        fails++;
        $display("FAIL latency_w%0d: lat=%0d single=%b, need %0d/1", WS[d], lat, one, WS[d] + 2);
      end
    end
  endtask
  task automatic test_back_to_back;
    int pos [$];
    int n;
    for (int d = 0; d < 3; d++) begin
      n = 3 * (WS[d] + 3);
      pos.delete();
      @(posedge clk); #1;
      we = 1'b0; addr = 32'hC; sel = 4'hF; req[d] = 1'b1;
      for (int c = 0; c < n; c++) begin
        @(negedge clk);
        if (rdy[d]) pos.push_back(c);
      end
      @(posedge clk); #1;
      req[d] = 1'b0;
      @(negedge clk);
      tests++;
      if (pos.size() != 3) begin
        fails++;
        $display("FAIL b2b_count_w%0d: %0d ready pulses, need 3", WS[d], pos.size());
      end else
        for (int i = 0; i < 3; i++) begin
          tests++;
          if (pos[i] != WS[d] + 2 + i * (WS[d] + 3)) begin
            fails++;
            $display("FAIL b2b_pos_w%0d: pulse %0d at %0d, need %0d", WS[d], i, pos[i], WS[d] + 2 + i * (WS[d] + 3));
          end
        end
    end
  endtask
  task automatic test_random;
    logic [31:0] r, xr, a, wd;
    logic e, xe, one, w;
    logic [3:0] s;
    int d, lat;
    for (int i = 0; i < 60; i++) begin
      d  = $urandom_range(0, 2);
      w  = 1'($urandom % 2);
      a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      if ($urandom % 8 == 0) a = a | (32'd1 << $urandom_range(14, 31));
      s  = ($urandom % 8 == 0) ? 4'd0 : 4'($urandom);
      wd = $urandom;
      model(d, w, a, s, wd, xr, xe);
      xact(d, w, a, s, wd, r, e, lat, one);
      tests++;
      if (r !== xr || e !== xe || lat != WS[d] + 2 || !one) begin
        fails++;
        $display("FAIL random_%0d: d=%0d we=%b a=%h sel=%h rdata=%h err=%b lat=%0d single=%b, need %h/%b/%0d/1",
                 i, d, w, a, s, r, e, lat, one, xr, xe, WS[d] + 2);
      end
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] r, xr;
    logic e, xe, one;
    int lat, seen;
    model(2, 1'b1, 32'h200, 4'hF, 32'h0, xr, xe);
    xact(2, 1'b1, 32'h200, 4'hF, 32'h0, r, e, lat, one);
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h200; sel = 4'hF; wdata = 32'h12345678; req[2] = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk); seen += int'(rdy[2]);
      @(posedge clk); #1;
    end
    rst = 1'b0; req[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) begin
      @(negedge clk); seen += int'(rdy[2]);
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_mid_ready: %0d ready pulses, need 0", seen);
    end
    xact(2, 1'b0, 32'h200, 4'hF, 32'h0, r, e, lat, one);
    tests++;
    if (r !== 32'h0 || e !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_write: rdata=%h err=%b, need 00000000/0", r, e);
    end
  endtask
  initial begin
    test_reset;
    init_mem;
    test_word;
    test_lanes;
    test_errors;
    test_timing;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
